// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the redirect path: decoded operation encoding and redirect FSM states.
package branch_redirect_ctrl_pkg;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_ALU   = 5'd1,
        OP_LOAD  = 5'd2,
        OP_STORE = 5'd3,
        OP_BEQ   = 5'd4,
        OP_BNE   = 5'd5,
        OP_BLT   = 5'd6,
        OP_BGE   = 5'd7,
        OP_BLTU  = 5'd8,
        OP_BGEU  = 5'd9,
        OP_JAL   = 5'd10,
        OP_JALR  = 5'd11
    } operation_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redir_state_t;

    function automatic logic is_jalr(input logic [4:0] op);
        return op == OP_JALR;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer behind execute: captures taken targets, requests fetch redirect, squashes the wrong path.
// redir_valid rises one cycle after the triggering transfer and holds (with redir_pc) until redir_ready.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rstf,
    input  logic            ex_valid,
    input  logic            ex_ready,
    input  logic            ex_branch_taken,
    input  logic [4:0]      ex_op,
    input  logic [XLEN-1:0] ex_target,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            kill,
    output logic            ex_kill,
    output logic            misalign_err,
    output logic [31:0]     perf_redirects
);

    localparam int unsigned CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((FLUSH_DEPTH == 0) ? 0 : FLUSH_DEPTH - 1);

    redir_state_t    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic [31:0]     perf_q, perf_d;

    logic [XLEN-1:0] tgt;
    logic            trigger;
    logic            misaligned;
    logic            accept;

    always_comb begin
        tgt = ex_target;
        if (is_jalr(ex_op)) tgt[0] = 1'b0;
    end

    // ex_kill is already zero in IDLE, so only a right-path instruction can trigger
    assign trigger    = ex_valid & ex_ready & ex_branch_taken & ~ex_kill & (state_q == IDLE);
    assign misaligned = tgt[1];
    assign accept     = (state_q == REDIRECT) & redir_ready;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            perf_q  <= perf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (trigger && !misaligned) state_d = REDIRECT;
            REDIRECT: if (redir_ready) state_d = (FLUSH_DEPTH == 0) ? IDLE : DRAIN;
            DRAIN:    if (cnt_q == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        pc_d   = pc_q;
        perf_d = perf_q;
        err_d  = trigger & misaligned;
        if (accept) begin
            cnt_d  = CNT_INIT;
            perf_d = perf_q + 32'd1;
        end else if (state_q == DRAIN && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (trigger && !misaligned) pc_d = tgt;
    end

    always_comb begin
        redir_valid = (state_q == REDIRECT);
        kill        = (state_q != IDLE);
        ex_kill     = ex_valid & (state_q != IDLE);
    end

    assign redir_pc       = pc_q;
    assign misalign_err   = err_q;
    assign perf_redirects = perf_q;

endmodule
